mix_pipe: RTL and testbench

Parametrised, handshaked state-mixing engine: accepts an N-lane vector of W-bit words, applies a fixed add/xor/shift round function for ROUNDS cycles (one round per clock), optionally applies a per-lane multiply-add finisher, then presents the result. It is the next generation of the single-cycle 8-register mixing block. Lane count, width and round count are generalised, and it adds flow control so it can sit between a seed producer and a hash/scramble consumer in the datapath.

---
 rtl/mix_pkg.sv | 24 ++
 rtl/mix_round.sv | 29 ++
 rtl/mix_pipe.sv | 114 +++++++++++
 tb/tb_mix_pipe.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mix_pkg.sv
// rtl/mix_pkg.sv - shared state encoding, default parameters and finisher lane constants for mix_pipe
package mix_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam int DEF_N      = 8;
    localparam int DEF_W      = 32;
    localparam int DEF_ROUNDS = 4;
    localparam int DEF_SHIFT  = 16;

    function automatic int lane_mul(input int i);
        return 2 * i + 3;
    endfunction

    function automatic int lane_add(input int i);
        return i;
    endfunction

endpackage

// File: rtl/mix_round.sv
// rtl/mix_round.sv - one combinational add/xor/shift mixing round across all lanes
module mix_round
    import mix_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int W     = DEF_W,
    parameter int SHIFT = DEF_SHIFT
) (
    input  logic [N*W-1:0] s_i,
    output logic [N*W-1:0] s_o
);

    for (genvar i = 0; i < N; i++) begin : g_lane
        localparam int PREV = (i + N - 1) % N;
        localparam int NEXT = (i + 1) % N;

        logic [W-1:0] cur;
        logic [W-1:0] prv;
        logic [W-1:0] nxt;

        assign cur = s_i[i*W +: W];
        assign prv = s_i[PREV*W +: W];
        assign nxt = s_i[NEXT*W +: W];

        // All operands are W bits wide, so the shift drops the high bits as intended.
        assign s_o[i*W +: W] = (cur + prv) ^ (nxt << SHIFT);
    end

endmodule

// File: rtl/mix_pipe.sv
// rtl/mix_pipe.sv - handshaked multi-round lane mixer; MIX_FINAL_MUL_EN adds the multiply-add finisher stage
module mix_pipe
    import mix_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int W      = DEF_W,
    parameter int ROUNDS = DEF_ROUNDS,
    parameter int SHIFT  = DEF_SHIFT
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*W-1:0] in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N*W-1:0] out_data,
    output logic           busy
);

    localparam int RW = $clog2(ROUNDS + 1);

    state_t          state_q, state_d;
    logic [RW-1:0]   rnd_q, rnd_d;
    logic [N*W-1:0]  s_q, s_d;
    logic [N*W-1:0]  load_v;
    logic [N*W-1:0]  round_v;
    logic            accept;

    mix_round #(.N(N), .W(W), .SHIFT(SHIFT)) u_round (
        .s_i (s_q),
        .s_o (round_v)
    );

    always_comb begin
        load_v = '0;
        for (int i = 0; i < N; i++) begin
            load_v[i*W +: W] = in_data[i*W +: W] + W'(i);
        end
    end

`ifdef MIX_FINAL_MUL_EN
    logic [N*W-1:0] fin_v;

    always_comb begin
        fin_v = '0;
        for (int i = 0; i < N; i++) begin
            fin_v[i*W +: W] = s_q[i*W +: W] * W'(lane_mul(i)) + W'(lane_add(i));
        end
    end
`endif

    // HOLD with out_ready can take the next vector on the hand-off edge, so no bubble.
    assign in_ready  = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == HOLD);
    assign out_data  = (state_q == HOLD) ? s_q : '0;
    assign busy      = (state_q == RUN) || (state_q == FIN);

    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        s_d     = s_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    s_d     = load_v;
                    rnd_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                s_d   = round_v;
                rnd_d = rnd_q + RW'(1);
                if (rnd_q == RW'(ROUNDS - 1)) begin
`ifdef MIX_FINAL_MUL_EN
                    state_d = FIN;
`else
                    state_d = HOLD;
`endif
                end
            end
`ifdef MIX_FINAL_MUL_EN
            FIN: begin
                s_d     = fin_v;
                state_d = HOLD;
            end
`endif
            HOLD: begin
                if (accept) begin
                    s_d     = load_v;
                    rnd_d   = '0;
                    state_d = RUN;
                end else if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rnd_q   <= '0;
            s_q     <= '0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            s_q     <= s_d;
        end
    end

endmodule

// File: tb/tb_mix_pipe.sv
// tb/tb_mix_pipe.sv - scoreboard bench for mix_pipe at default, 4-lane and 8-bit wrap configurations
module tb_mix_pipe;

`ifdef MIX_FINAL_MUL_EN
    localparam int FL = 1;
`else
    localparam int FL = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [255:0] in_data, out_data;

    logic         s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_busy;
    logic [127:0] s_in_data, s_out_data;

    logic         w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_busy;
    logic [15:0]  w_in_data, w_out_data;

    mix_pipe u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    mix_pipe #(.N(4), .W(32), .ROUNDS(1), .SHIFT(16)) u_small (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data), .busy(s_busy)
    );

    mix_pipe #(.N(2), .W(8), .ROUNDS(1), .SHIFT(4)) u_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready), .in_data(w_in_data),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data), .busy(w_busy)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: load, ROUNDS rounds, optional finisher, all as plain modular arithmetic.
    function automatic logic [255:0] ref_mix(input int n, input int w, input int rounds,
                                             input int shift, input logic [255:0] din);
        logic [63:0]  s [8];
        logic [63:0]  t [8];
        logic [63:0]  mask;
        logic [255:0] tmp;
        logic [255:0] r;
        mask = (64'd1 << w) - 64'd1;
        for (int i = 0; i < n; i++) begin
            tmp  = din >> (i * w);
            s[i] = (tmp[63:0] + 64'(i)) & mask;
        end
        for (int k = 0; k < rounds; k++) begin
            for (int i = 0; i < n; i++)
                t[i] = ((s[i] + s[(i + n - 1) % n]) ^ (s[(i + 1) % n] << shift)) & mask;
            for (int i = 0; i < n; i++) s[i] = t[i];
        end
`ifdef MIX_FINAL_MUL_EN
        for (int i = 0; i < n; i++) s[i] = (s[i] * 64'(2 * i + 3) + 64'(i)) & mask;
`endif
        r = '0;
        for (int i = 0; i < n; i++) r = r | (256'(s[i]) << (i * w));
        return r;
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    logic [255:0] sb_q[$];
    logic [255:0] exp_v;
    logic [255:0] hold_d;
    logic         hold_stall = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_stall <= 1'b0;
        end else begin
            if (hold_stall) begin
                check("stall_valid", 256'(out_valid), 256'd1);
                check("stall_data", out_data, hold_d);
            end
            if (in_valid && in_ready) sb_q.push_back(ref_mix(8, 32, 4, 16, in_data));
            if (in_valid && busy) check("busy_in_ready", 256'(in_ready), 256'd0);
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_unexpected: output %h with empty scoreboard", out_data);
                end else begin
                    exp_v = sb_q.pop_front();
                    check("sb_data", out_data, exp_v);
                end
            end
            hold_stall <= out_valid && !out_ready;
            hold_d     <= out_data;
        end
    end

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, 256'(sb_q.size()), 256'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [255:0] v;
        logic [255:0] held;
        int n;
        logic done;

        in_valid = 0; in_data = '0; out_ready = 1;
        s_in_valid = 0; s_in_data = '0; s_out_ready = 1;
        w_in_valid = 0; w_in_data = '0; w_out_ready = 1;
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;

        @(negedge clk);
        check("rst_out_valid", 256'(out_valid), 256'd0);
        check("rst_busy", 256'(busy), 256'd0);
        check("rst_in_ready", 256'(in_ready), 256'd1);
        check("rst_out_data", out_data, 256'd0);

        // Directed all-zero 4-lane vector and 8-bit wrap-around vector, side by side.
        @(posedge clk); #1;
        s_in_valid = 1; s_in_data = '0;
        w_in_valid = 1; w_in_data = 16'hFFFF;
        @(negedge clk);
        check("small_in_ready", 256'(s_in_ready), 256'd1);
        @(posedge clk); #1;
        s_in_valid = 0; w_in_valid = 0;
        @(negedge clk);
        check("small_busy", 256'(s_busy), 256'd1);
        check("small_early_valid", 256'(s_out_valid), 256'd0);
        check("wrap_busy", 256'(w_busy), 256'd1);
        for (int k = 1; k <= 1 + FL; k++) begin
            @(negedge clk);
            if (k < 1 + FL) check("small_fin_valid", 256'(s_out_valid), 256'd0);
        end
        check("small_valid", 256'(s_out_valid), 256'd1);
        check("small_data", {128'd0, s_out_data}, ref_mix(4, 32, 1, 16, 256'd0));
        check("wrap_valid", 256'(w_out_valid), 256'd1);
        check("wrap_data", {240'd0, w_out_data}, ref_mix(2, 8, 1, 4, 256'hFFFF));
        @(negedge clk);
        check("small_valid_drop", 256'(s_out_valid), 256'd0);
        check("small_data_zero", {128'd0, s_out_data}, 256'd0);
        check("wrap_valid_drop", 256'(w_out_valid), 256'd0);

        // Back-pressure then zero-bubble hand-off on the default configuration.
        @(posedge clk); #1;
        in_valid = 1; in_data = rnd256(); out_ready = 0;
        @(posedge clk); #1;
        in_valid = 0;
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("main_latency", 256'(n - 1), 256'(4 + FL));
        held = out_data;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("bp_in_ready", 256'(in_ready), 256'd0);
            check("bp_valid", 256'(out_valid), 256'd1);
            check("bp_data", out_data, held);
        end
        @(posedge clk); #1;
        out_ready = 1; in_valid = 1; in_data = rnd256();
        @(negedge clk);
        check("handoff_in_ready", 256'(in_ready), 256'd1);
        @(posedge clk); #1;
        in_valid = 0;
        @(negedge clk);
        check("handoff_busy", 256'(busy), 256'd1);
        check("handoff_valid", 256'(out_valid), 256'd0);
        drain("bp_drain");

        // Reset in the middle of a run, then rerun the same vector.
        v = rnd256();
        @(posedge clk); #1;
        in_valid = 1; in_data = v;
        @(posedge clk); #1;
        in_valid = 0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        sb_q.delete();
        @(negedge clk);
        check("midrst_valid", 256'(out_valid), 256'd0);
        check("midrst_busy", 256'(busy), 256'd0);
        check("midrst_in_ready", 256'(in_ready), 256'd1);
        check("midrst_data", out_data, 256'd0);
        @(posedge clk); #1;
        in_valid = 1; in_data = v;
        @(posedge clk); #1;
        in_valid = 0;
        drain("midrst_drain");

        // Random traffic with random consumer stalls; junk data changes while blocked.
        done = 0;
        fork
            begin
                for (int vi = 0; vi < 100; vi++) begin
                    logic acc;
                    int   m;
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk); #1;
                    end
                    in_valid = 1;
                    in_data  = rnd256();
                    acc = 0;
                    m   = 0;
                    while (!acc && m < 100) begin
                        @(negedge clk);
                        acc = in_ready;
                        @(posedge clk); #1;
                        if (!acc) in_data = rnd256();
                        m++;
                    end
                    in_valid = 0;
                    if (!acc) begin
                        tests++;
                        fails++;
                        $display("FAIL rand_accept: vector %0d not accepted in %0d cycles", vi, m);
                    end
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1;
        drain("rand_drain");

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
